// File: rtl/mlcp_dot_accel.sv
// rtl/mlcp_dot_accel.sv - memory-mapped signed int16 dot-product accelerator
// Two-stage multiply/accumulate pipeline fed from A/B vector buffers, one element per cycle.
module mlcp_dot_accel #(
    parameter int DEPTH = 16,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cp_sel,
    input  logic        cp_we,
    input  logic        cp_re,
    input  logic [7:0]  cp_addr,
    input  logic [31:0] cp_wdata,
    output logic [31:0] cp_rdata,
    output logic        irq
);

    localparam int IW = $clog2(DEPTH);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [4:0]    DEPTH_5 = 5'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [LW-1:0]  len_q, len_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [31:0]    acc_q, acc_d;
    logic [31:0]    prod_q, prod_d;
    logic [31:0]    result_q, result_d;
    logic           pvalid_q, pvalid_d;
    logic           done_q, done_d;
    logic           ie_q, ie_d;
    logic           ovf_q, ovf_d;

    // Vector buffers are deliberately not reset so their contents survive rst.
    logic [15:0]    a_q [DEPTH];
    logic [15:0]    b_q [DEPTH];

    logic           wr, rd, busy;
    logic           ctrl_wr, len_wr, a_hit, b_hit, start_ok, last_elem;
    logic [IW-1:0]  buf_idx;
    logic [LW-1:0]  len_m1;
    logic [31:0]    a_ext, b_ext, prod_new, sum, rdata;
    logic           sum_ovf;

    assign wr       = cp_sel & cp_we;
    assign rd       = cp_sel & cp_re;
    assign busy     = (state_q == RUN) || (state_q == DRAIN);
    assign ctrl_wr  = wr && (cp_addr[7:2] == 6'h00);
    assign len_wr   = wr && (cp_addr[7:2] == 6'h02);
    assign buf_idx  = cp_addr[IW+1:2];
    assign a_hit    = (cp_addr[7:6] == 2'b01) && ({1'b0, cp_addr[5:2]} < DEPTH_5);
    assign b_hit    = (cp_addr[7:6] == 2'b10) && ({1'b0, cp_addr[5:2]} < DEPTH_5);
    assign start_ok = ctrl_wr && cp_wdata[0] && (state_q == IDLE);
    assign len_m1   = len_q - 1'b1;
    assign last_elem = ({1'b0, idx_q} == len_m1);

    assign a_ext    = {{16{a_q[idx_q][15]}}, a_q[idx_q]};
    assign b_ext    = {{16{b_q[idx_q][15]}}, b_q[idx_q]};
    // Low 32 bits of the sign-extended product equal the exact int16*int16 result.
    assign prod_new = a_ext * b_ext;
    assign sum      = acc_q + prod_q;
    assign sum_ovf  = (acc_q[31] == prod_q[31]) && (sum[31] != acc_q[31]);

    always_ff @(posedge clk) begin
        if (wr && a_hit && !busy) a_q[buf_idx] <= cp_wdata[15:0];
        if (wr && b_hit && !busy) b_q[buf_idx] <= cp_wdata[15:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            len_q    <= '0;
            idx_q    <= '0;
            acc_q    <= '0;
            prod_q   <= '0;
            result_q <= '0;
            pvalid_q <= 1'b0;
            done_q   <= 1'b0;
            ie_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            prod_q   <= prod_d;
            result_q <= result_d;
            pvalid_q <= pvalid_d;
            done_q   <= done_d;
            ie_q     <= ie_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok && (len_q != '0)) state_d = RUN;
            RUN:     if (last_elem) state_d = DRAIN;
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        len_d    = len_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        prod_d   = prod_q;
        result_d = result_q;
        pvalid_d = pvalid_q;
        done_d   = done_q;
        ie_d     = ie_q;
        ovf_d    = ovf_q;

        if (ctrl_wr) begin
            ie_d = cp_wdata[2];
            if (cp_wdata[1]) done_d = 1'b0;
        end
        if (len_wr && !busy) begin
            len_d = (cp_wdata > 32'(DEPTH)) ? DEPTH_L : cp_wdata[LW-1:0];
        end

        // FSM effects come after clear_done so a completing run's done set wins.
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    ovf_d = 1'b0;
                    if (len_q == '0) begin
                        done_d   = 1'b1;
                        result_d = '0;
                    end else begin
                        done_d   = 1'b0;
                        acc_d    = '0;
                        idx_d    = '0;
                        pvalid_d = 1'b0;
                    end
                end
            end
            RUN: begin
                prod_d   = prod_new;
                pvalid_d = 1'b1;
                idx_d    = idx_q + 1'b1;
                if (pvalid_q) begin
                    acc_d = sum;
                    if (sum_ovf) ovf_d = 1'b1;
                end
            end
            DRAIN: begin
                result_d = sum;
                done_d   = 1'b1;
                pvalid_d = 1'b0;
                if (sum_ovf) ovf_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        rdata = '0;
        case (cp_addr[7:2])
            6'h01:   rdata = {28'd0, ovf_q, ie_q, done_q, busy};
            6'h02:   rdata = 32'(len_q);
            6'h03:   rdata = result_q;
            default: begin
                if (a_hit) rdata = {{16{a_q[buf_idx][15]}}, a_q[buf_idx]};
                if (b_hit) rdata = {{16{b_q[buf_idx][15]}}, b_q[buf_idx]};
            end
        endcase
    end

    assign cp_rdata = rd ? rdata : 32'd0;
    assign irq      = done_q & ie_q;

endmodule

// File: tb/tb_mlcp_dot_accel.sv
// tb/tb_mlcp_dot_accel.sv - self-checking bench for mlcp_dot_accel
module tb_mlcp_dot_accel;

    logic        clk = 1'b0;
    logic        rst;
    logic        cp_sel, cp_we, cp_re;
    logic [7:0]  cp_addr;
    logic [31:0] cp_wdata;
    logic [31:0] cp_rdata;
    logic        irq;

    int n_cmp  = 0;
    int n_fail = 0;

    shortint a_m [16];
    shortint b_m [16];

    mlcp_dot_accel dut (
        .clk      (clk),
        .rst      (rst),
        .cp_sel   (cp_sel),
        .cp_we    (cp_we),
        .cp_re    (cp_re),
        .cp_addr  (cp_addr),
        .cp_wdata (cp_wdata),
        .cp_rdata (cp_rdata),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  waddr;
        logic [31:0] wdata;
        logic [7:0]  raddr;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drives at a falling edge, the write lands on the next rising edge.
    task automatic wr(input logic [7:0] addr, input logic [31:0] data);
        @(negedge clk);
        cp_sel = 1'b1; cp_we = 1'b1; cp_addr = addr; cp_wdata = data;
        @(negedge clk);
        cp_sel = 1'b0; cp_we = 1'b0; cp_wdata = '0;
    endtask

    task automatic rd_now(input logic [7:0] addr, output logic [31:0] data);
        cp_sel = 1'b1; cp_re = 1'b1; cp_addr = addr;
        #1;
        data = cp_rdata;
        cp_sel = 1'b0; cp_re = 1'b0;
    endtask

    // Called right after a start write; counts cycles with busy set.
    task automatic wait_idle(output int cycles);
        logic [31:0] st;
        cycles = 0;
        for (int i = 0; i < 200; i++) begin
            rd_now(8'h04, st);
            if (!st[0]) return;
            cycles++;
            @(negedge clk);
        end
        n_cmp++; n_fail++;
        $display("FAIL timeout: busy still set after 200 cycles");
    endtask

    task automatic load(input int idx, input shortint a, input shortint b);
        wr(8'h40 + 8'(idx * 4), {16'hDEAD, a});
        wr(8'h80 + 8'(idx * 4), {16'hBEEF, b});
        a_m[idx] = a;
        b_m[idx] = b;
    endtask

    // Reference: plain signed sum with per-step overflow detection on a wrapping int.
    task automatic model(input int n, output logic [31:0] res, output logic ov);
        int     acc;
        longint s;
        acc = 0; ov = 1'b0;
        for (int i = 0; i < n; i++) begin
            s = longint'(acc) + longint'(int'(a_m[i]) * int'(b_m[i]));
            if (s > 64'sd2147483647 || s < -64'sd2147483648) ov = 1'b1;
            acc = int'(s);
        end
        res = acc;
    endtask

    vec_t        tbl [8];
    logic [31:0] r, exp_r;
    logic        exp_ov;
    int          cyc, n;

    initial begin
        rst = 1'b1; cp_sel = 1'b0; cp_we = 1'b0; cp_re = 1'b0;
        cp_addr = '0; cp_wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("reset_irq", {31'd0, irq}, 32'd0);
        cp_sel = 1'b1; cp_addr = 8'h04; #1;
        check("reset_rdata_noload", cp_rdata, 32'd0);
        cp_sel = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd_now(8'(i * 4), r);
            check($sformatf("reset_reg_%0h", i * 4), r, 32'd0);
        end

        tbl[0] = '{8'h4C, 32'h1234ABCD, 8'h4C, 32'hFFFFABCD};
        tbl[1] = '{8'hBC, 32'h00007FFF, 8'hBC, 32'h00007FFF};
        tbl[2] = '{8'h81, 32'h00008000, 8'h80, 32'hFFFF8000};
        tbl[3] = '{8'h08, 32'd5,        8'h08, 32'd5};
        tbl[4] = '{8'h08, 32'd16,       8'h08, 32'd16};
        tbl[5] = '{8'h08, 32'd17,       8'h08, 32'd16};
        tbl[6] = '{8'h10, 32'hFFFFFFFF, 8'h10, 32'd0};
        tbl[7] = '{8'h00, 32'h00000000, 8'h00, 32'd0};
        foreach (tbl[i]) begin
            wr(tbl[i].waddr, tbl[i].wdata);
            rd_now(tbl[i].raddr, r);
            check($sformatf("table_%0d", i), r, tbl[i].exp);
        end

        load(0, 1, 5); load(1, 2, 6); load(2, 3, 7); load(3, 4, 8);
        wr(8'h08, 32'd4);
        wr(8'h00, 32'h1);
        wait_idle(cyc);
        check("basic_busy_cycles", cyc, 32'd5);
        rd_now(8'h04, r); check("basic_status", r, 32'h2);
        rd_now(8'h0C, r); check("basic_result", r, 32'd70);

        load(0, -3, 7); load(1, 100, -2);
        wr(8'h08, 32'd2);
        wr(8'h00, 32'h5);
        check("irq_low_busy", {31'd0, irq}, 32'd0);
        wait_idle(cyc);
        check("irq_rise_with_done", {31'd0, irq}, 32'd1);
        rd_now(8'h0C, r); check("neg_result", r, 32'hFFFFFF23);
        rd_now(8'h04, r); check("neg_status", r, 32'h6);
        wr(8'h00, 32'h6);
        check("irq_after_clear", {31'd0, irq}, 32'd0);
        wr(8'h00, 32'h0);

        for (int i = 0; i < 16; i++) load(i, 16'sh7FFF, 16'sh7FFF);
        wr(8'h08, 32'd20);
        rd_now(8'h08, r); check("len_clamp", r, 32'd16);
        wr(8'h00, 32'h1);
        wait_idle(cyc);
        check("full_cycles", cyc, 32'd17);
        rd_now(8'h0C, r); check("full_result", r, 32'hFFF00010);
        rd_now(8'h04, r); check("full_status", r, 32'hA);

        wr(8'h00, 32'h1);
        wr(8'h40, 32'd99);
        wr(8'h08, 32'd1);
        rd_now(8'h0C, r); check("result_while_busy", r, 32'hFFF00010);
        wr(8'h00, 32'h1);
        wait_idle(cyc);
        rd_now(8'h0C, r); check("ignored_result", r, 32'hFFF00010);
        rd_now(8'h40, r); check("ignored_a0", r, 32'h00007FFF);
        rd_now(8'h08, r); check("ignored_len", r, 32'd16);

        wr(8'h00, 32'h2);
        wr(8'h08, 32'd0);
        wr(8'h00, 32'h1);
        rd_now(8'h04, r); check("len0_status", r, 32'h2);
        rd_now(8'h0C, r); check("len0_result", r, 32'd0);

        for (int i = 0; i < 8; i++) load(i, shortint'($urandom), shortint'($urandom));
        wr(8'h08, 32'd8);
        wr(8'h00, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rd_now(8'h04, r); check("rst_status", r, 32'd0);
        rd_now(8'h0C, r); check("rst_result", r, 32'd0);
        rd_now(8'h08, r); check("rst_len", r, 32'd0);
        wr(8'h08, 32'd8);
        wr(8'h00, 32'h1);
        wait_idle(cyc);
        model(8, exp_r, exp_ov);
        rd_now(8'h0C, r); check("rst_rerun_result", r, exp_r);
        rd_now(8'h04, r); check("rst_rerun_ovf", {31'd0, r[3]}, {31'd0, exp_ov});

        for (int t = 0; t < 20; t++) begin
            n = $urandom_range(1, 16);
            for (int i = 0; i < n; i++) begin
                if (t % 3 == 0)
                    load(i, shortint'($urandom_range(30000, 32767)), shortint'($urandom_range(30000, 32767)));
                else
                    load(i, shortint'($urandom), shortint'($urandom));
            end
            wr(8'h08, 32'(n));
            wr(8'h00, 32'h1);
            wait_idle(cyc);
            model(n, exp_r, exp_ov);
            check($sformatf("rand_%0d_cycles", t), cyc, 32'(n + 1));
            rd_now(8'h0C, r); check($sformatf("rand_%0d_result", t), r, exp_r);
            rd_now(8'h04, r); check($sformatf("rand_%0d_status", t), r, {28'd0, exp_ov, 3'b010});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
